// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
//  Shared constants and types for the CONV host-side memory block:
//  data width, memory-select codes, memory depths and the handshake FSM
//  state encoding.
// ----------------------------------------------------------------------------
package conv_pkg;

   localparam int DW        = 20;     // signed Q4.16 sample width
   localparam int IMG_DEPTH = 4096;   // 64x64 image, also the L0 depth
   localparam int IMG_AW    = 12;
   localparam int L1_DEPTH  = 1024;   // 32x32 pooled layer
   localparam int L1_AW     = 10;

   localparam logic [2:0] CSEL_L0 = 3'b001;
   localparam logic [2:0] CSEL_L1 = 3'b011;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READY = 3'd1,
      ST_RUN   = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } conv_state_e;

   // States in which the host owns the image ROM and will accept a new start.
   function automatic logic host_owned(input conv_state_e s);
      return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
   endfunction

   // States in which CONV may write the layer memories.
   function automatic logic conv_owned(input conv_state_e s);
      return (s == ST_READY) || (s == ST_RUN);
   endfunction

endpackage

// File: rtl/conv_layer_ram.sv
// ----------------------------------------------------------------------------
// conv_layer_ram
//  Layer result memory: one synchronous write port, one combinational read
//  port for CONV, and an independent registered dump port for readback.
//  Contents are not reset; only the dump output register is.
// Ports
//  clk      in   clock, rising edge
//  reset    in   asynchronous active-high reset (dump register only)
//  we_i     in   write enable
//  waddr_i  in   write address
//  wdata_i  in   write data
//  raddr_i  in   combinational read address
//  rdata_o  out  combinational read data (old data on same-cycle write)
//  daddr_i  in   dump address
//  ddata_o  out  dump data, one-cycle latency
// ----------------------------------------------------------------------------
module conv_layer_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10,
   parameter int W     = conv_pkg::DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o,
   input  logic [AW-1:0] daddr_i,
   output logic [W-1:0]  ddata_o
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] ddata_q;

   // Storage write port; memory contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

   // Dump port register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ddata_q <= {W{1'b0}};
      end else begin
         ddata_q <= mem_q[daddr_i];
      end
   end

   assign ddata_o = ddata_q;

endmodule

// File: rtl/conv_host_mem.sv
// ----------------------------------------------------------------------------
// conv_host_mem
//  Host/responder side of the CONV accelerator interface. Holds the image ROM
//  (loaded through ld_*), the L0 and L1 result memories, runs the ready/busy
//  start handshake, flags a no-response timeout and provides a dump port.
// Ports
//  clk, reset            clock / asynchronous active-high reset
//  ld_en/ld_addr/ld_data image load port (only while the host owns the ROM)
//  start                 begin a run
//  ready                 to CONV: image available (registered)
//  busy                  from CONV: processing
//  iaddr/idata           combinational image read
//  cwr/caddr_wr/cdata_wr layer-memory write
//  crd/caddr_rd/cdata_rd layer-memory combinational read
//  csel                  memory select (001 = L0, 011 = L1)
//  finish                one-cycle pulse at run end
//  err_timeout           sticky: CONV never raised busy
//  dump_sel/dump_addr    dump select (0 = L0, 1 = L1) and address
//  dump_data             registered dump data, one-cycle latency
//  l0_wr_cnt/l1_wr_cnt   saturating per-run write counters
// ----------------------------------------------------------------------------
module conv_host_mem #(
   parameter int DW          = conv_pkg::DW,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld_en,
   input  logic [11:0]      ld_addr,
   input  logic [DW-1:0]    ld_data,
   input  logic             start,
   output logic             ready,
   input  logic             busy,
   input  logic [11:0]      iaddr,
   output logic [DW-1:0]    idata,
   input  logic             cwr,
   input  logic [11:0]      caddr_wr,
   input  logic [DW-1:0]    cdata_wr,
   input  logic             crd,
   input  logic [11:0]      caddr_rd,
   output logic [DW-1:0]    cdata_rd,
   input  logic [2:0]       csel,
   output logic             finish,
   output logic             err_timeout,
   input  logic             dump_sel,
   input  logic [11:0]      dump_addr,
   output logic [DW-1:0]    dump_data,
   output logic [CNT_W-1:0] l0_wr_cnt,
   output logic [CNT_W-1:0] l1_wr_cnt
);

   import conv_pkg::*;

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   conv_state_e      state_q, state_d;
   logic             ready_q, ready_d;
   logic             finish_q, finish_d;
   logic             err_q, err_d;
   logic             busy_prev_q;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [CNT_W-1:0] l0_cnt_q, l0_cnt_d;
   logic [CNT_W-1:0] l1_cnt_q, l1_cnt_d;
   logic             dump_sel_q;
   logic             run_clear_s;
   logic             l0_we_s, l1_we_s;
   logic [DW-1:0]    l0_rdata_s, l1_rdata_s;
   logic [DW-1:0]    l0_ddata_s, l1_ddata_s;
   logic [DW-1:0]    img_q [IMG_DEPTH];

   // ---------------- handshake FSM ----------------

   // Next-state logic; tmo_q counts edges spent in READY without busy.
   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      run_clear_s = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d     = ST_READY;
               tmo_d       = {TMO_W{1'b0}};
               run_clear_s = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_READY: begin
            if (busy) begin
               state_d = ST_RUN;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_ERR;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_RUN: begin
            // busy was 1 on entry, so a 1->0 transition ends the run
            if (busy_prev_q && !busy) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered status outputs derived from the transition being taken.
   always_comb begin
      ready_d  = (state_d == ST_READY);
      finish_d = (state_q == ST_RUN) && (state_d == ST_DONE);
      if (run_clear_s) begin
         err_d = 1'b0;
      end else if ((state_q == ST_READY) && (state_d == ST_ERR)) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Saturating write counters, cleared when a new run starts.
   always_comb begin
      l0_we_s = cwr && (csel == CSEL_L0) && conv_owned(state_q);
      l1_we_s = cwr && (csel == CSEL_L1) && conv_owned(state_q);
      if (run_clear_s) begin
         l0_cnt_d = {CNT_W{1'b0}};
      end else if (l0_we_s && !(&l0_cnt_q)) begin
         l0_cnt_d = l0_cnt_q + CNT_W'(1);
      end else begin
         l0_cnt_d = l0_cnt_q;
      end
      if (run_clear_s) begin
         l1_cnt_d = {CNT_W{1'b0}};
      end else if (l1_we_s && !(&l1_cnt_q)) begin
         l1_cnt_d = l1_cnt_q + CNT_W'(1);
      end else begin
         l1_cnt_d = l1_cnt_q;
      end
   end

   // State, status and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b0;
         finish_q    <= 1'b0;
         err_q       <= 1'b0;
         busy_prev_q <= 1'b0;
         tmo_q       <= {TMO_W{1'b0}};
         l0_cnt_q    <= {CNT_W{1'b0}};
         l1_cnt_q    <= {CNT_W{1'b0}};
         dump_sel_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         finish_q    <= finish_d;
         err_q       <= err_d;
         busy_prev_q <= busy;
         tmo_q       <= tmo_d;
         l0_cnt_q    <= l0_cnt_d;
         l1_cnt_q    <= l1_cnt_d;
         dump_sel_q  <= dump_sel;
      end
   end

   assign ready       = ready_q;
   assign finish      = finish_q;
   assign err_timeout = err_q;
   assign l0_wr_cnt   = l0_cnt_q;
   assign l1_wr_cnt   = l1_cnt_q;

   // ---------------- image ROM ----------------

   // Image load port; frozen while CONV owns the image.
   always_ff @(posedge clk) begin
      if (ld_en && host_owned(state_q)) begin
         img_q[ld_addr] <= ld_data;
      end
   end

   assign idata = img_q[iaddr];

   // ---------------- layer memories ----------------

   conv_layer_ram #(.DEPTH(IMG_DEPTH), .AW(IMG_AW), .W(DW)) u_l0 (
      .clk     (clk),
      .reset   (reset),
      .we_i    (l0_we_s),
      .waddr_i (caddr_wr),
      .wdata_i (cdata_wr),
      .raddr_i (caddr_rd),
      .rdata_o (l0_rdata_s),
      .daddr_i (dump_addr),
      .ddata_o (l0_ddata_s)
   );

   conv_layer_ram #(.DEPTH(L1_DEPTH), .AW(L1_AW), .W(DW)) u_l1 (
      .clk     (clk),
      .reset   (reset),
      .we_i    (l1_we_s),
      .waddr_i (caddr_wr[L1_AW-1:0]),
      .wdata_i (cdata_wr),
      .raddr_i (caddr_rd[L1_AW-1:0]),
      .rdata_o (l1_rdata_s),
      .daddr_i (dump_addr[L1_AW-1:0]),
      .ddata_o (l1_ddata_s)
   );

   // CONV read mux; an invalid select or crd=0 reads as zero.
   always_comb begin
      if (crd && (csel == CSEL_L0)) begin
         cdata_rd = l0_rdata_s;
      end else if (crd && (csel == CSEL_L1)) begin
         cdata_rd = l1_rdata_s;
      end else begin
         cdata_rd = {DW{1'b0}};
      end
   end

   // Both dump ports are registered; the select is registered alongside them.
   always_comb begin
      if (dump_sel_q) begin
         dump_data = l1_ddata_s;
      end else begin
         dump_data = l0_ddata_s;
      end
   end

endmodule
